// File: rtl/modinv_pkg.sv
// modinv_pkg: shared FSM state type and step-bound helper for the modular inverter.
package modinv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} modinv_state_t;
  function automatic int modinv_max_steps(input int logq);
    return 4 * logq + 1;
  endfunction
endpackage

// File: rtl/modinv_step.sv
// modinv_step: one combinational binary extended-Euclid step with x1/x2 kept in [0, qr).
module modinv_step
  import modinv_pkg::*;
#(
  parameter int LOGQ = 32
) (
  input  logic [LOGQ-1:0] u,
  input  logic [LOGQ-1:0] v,
  input  logic [LOGQ-1:0] x1,
  input  logic [LOGQ-1:0] x2,
  input  logic [LOGQ-1:0] qr,
  output logic [LOGQ-1:0] u_n,
  output logic [LOGQ-1:0] v_n,
  output logic [LOGQ-1:0] x1_n,
  output logic [LOGQ-1:0] x2_n
);
  // x/2 mod m for odd m; the extra sum bit keeps x+m from overflowing
  function automatic logic [LOGQ-1:0] half(input logic [LOGQ-1:0] x, input logic [LOGQ-1:0] m);
    logic [LOGQ:0] s;
    s = {1'b0, x} + (x[0] ? {1'b0, m} : '0);
    return s[LOGQ:1];
  endfunction
  function automatic logic [LOGQ-1:0] modsub(input logic [LOGQ-1:0] a, input logic [LOGQ-1:0] b,
                                             input logic [LOGQ-1:0] m);
    logic [LOGQ:0] d;
    logic [LOGQ:0] s;
    d = {1'b0, a} - {1'b0, b};
    s = d + {1'b0, m};
    return d[LOGQ] ? s[LOGQ-1:0] : d[LOGQ-1:0];
  endfunction
  always_comb begin
    u_n  = u;
    v_n  = v;
    x1_n = x1;
    x2_n = x2;
    if (!u[0]) begin
      u_n  = u >> 1;
      x1_n = half(x1, qr);
    end else if (!v[0]) begin
      v_n  = v >> 1;
      x2_n = half(x2, qr);
    end else if (u >= v) begin
      u_n  = u - v;
      x1_n = modsub(x1, x2, qr);
    end else begin
      v_n  = v - u;
      x2_n = modsub(x2, x1, qr);
    end
  end
endmodule

// File: rtl/modinv.sv
// modinv: sequential A^-1 mod q, one binary extended-Euclid step per clock.
// Define MODINV_ERR_CHECK_EN to report non-invertible operands and step-bound overruns on err.
module modinv
  import modinv_pkg::*;
#(
  parameter int LOGQ = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [LOGQ-1:0] A,
  input  logic [LOGQ-1:0] q,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGQ-1:0] T,
  output logic            err
);
  localparam int MAXS = modinv_max_steps(LOGQ);
  localparam int CW   = $clog2(MAXS + 1);
`ifdef MODINV_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif
  modinv_state_t   state_q, state_d;
  logic [LOGQ-1:0] u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d, qr_q, qr_d, t_q, t_d;
  logic [LOGQ-1:0] u_n, v_n, x1_n, x2_n;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d, in_ready_q, in_ready_d, err_q, err_d;
  modinv_step #(.LOGQ(LOGQ)) u_step (
    .u(u_q), .v(v_q), .x1(x1_q), .x2(x2_q), .qr(qr_q),
    .u_n(u_n), .v_n(v_n), .x1_n(x1_n), .x2_n(x2_n)
  );
  always_comb begin
    state_d     = state_q;
    u_d         = u_q;
    v_d         = v_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    qr_d        = qr_q;
    t_d         = t_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      IDLE: if (in_valid && in_ready_q) begin
        u_d        = A;
        v_d        = q;
        x1_d       = LOGQ'(1);
        x2_d       = '0;
        qr_d       = q;
        cnt_d      = '0;
        in_ready_d = 1'b0;
        state_d    = RUN;
      end
      RUN: if (u_q == LOGQ'(1) || v_q == LOGQ'(1)) begin
        t_d     = (u_q == LOGQ'(1)) ? x1_q : x2_q;
        err_d   = 1'b0;
        state_d = DONE;
      end else if (u_q == '0 || v_q == '0 || cnt_q == CW'(MAXS)) begin
        t_d     = '0;
        err_d   = ERR_EN;
        state_d = DONE;
      end else begin
        u_d   = u_n;
        v_d   = v_n;
        x1_d  = x1_n;
        x2_d  = x2_n;
        cnt_d = cnt_q + 1'b1;
      end
      DONE: if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end else begin
        out_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      u_q         <= '0;
      v_q         <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      qr_q        <= '0;
      t_q         <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      u_q         <= u_d;
      v_q         <= v_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      qr_q        <= qr_d;
      t_q         <= t_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign T         = t_q;
  assign err       = err_q;
endmodule
